// File: rtl/tdc_ctrl_pkg.sv
// Shared types and default parameter values for the TDC window controller.
package tdc_ctrl_pkg;

    localparam int unsigned DEF_BIT_COUNT     = 32;
    localparam int unsigned DEF_MAX_WINDOW    = 4096;
    localparam int unsigned DEF_CLEAR_CYCLES  = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_TW            = $clog2(DEF_MAX_WINDOW + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        MEASURE,
        SETTLE,
        HOLD
    } tdc_state_t;

    // Result record laid out at the default widths.
    typedef struct packed {
        logic [DEF_BIT_COUNT-1:0] count;
        logic [DEF_TW-1:0]        window;
        logic                     timeout;
        logic                     stale;
    } tdc_result_t;

endpackage

// File: rtl/tdc_edge_detect.sv
// Registered-history rising-edge detector; the pulse is high in the cycle the input first reads 1.
module tdc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // NOTE: clocked state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/tdc_window_controller.sv
// Measurement sequencer: clears the oscillator counter, gates its enable between start and stop,
// waits for the count to settle, captures it and offers it to readout over valid/ready.
module tdc_window_controller
    import tdc_ctrl_pkg::*;
#(
    parameter  int unsigned BIT_COUNT     = DEF_BIT_COUNT,
    parameter  int unsigned MAX_WINDOW    = DEF_MAX_WINDOW,
    parameter  int unsigned CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int unsigned TW            = $clog2(MAX_WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 start,
    input  logic                 stop,
    output logic                 cnt_enable,
    output logic                 cnt_reset,
    input  logic [BIT_COUNT-1:0] cnt_value,
    input  logic                 cnt_has_value,
    output logic [BIT_COUNT-1:0] result,
    output logic [TW-1:0]        result_window,
    output logic                 result_timeout,
    output logic                 result_stale,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy
);

    localparam int unsigned   CW         = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned   SW         = $clog2(4 * SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CLEAR_ONE  = CW'(1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] WIN_LIMIT  = TW'(MAX_WINDOW);
    localparam logic [SW-1:0] SETTLE_ONE = SW'(1);
    localparam logic [SW-1:0] SETTLE_MIN = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(4 * SETTLE_CYCLES);

    typedef struct packed {
        logic [BIT_COUNT-1:0] count;
        logic [TW-1:0]        window;
        logic                 timeout;
        logic                 stale;
    } result_t;

    tdc_state_t    r_state, w_next_state;
    logic          w_start_edge, w_stop_edge, w_stop_hit, w_win_full, w_has_ready, w_capture;
    logic          w_cnt_enable_d, w_cnt_reset_d, w_valid_d;
    logic          r_cnt_enable, r_cnt_reset, r_valid, r_stop_seen, r_timeout_cap;
    logic [CW-1:0] r_clear;
    logic [TW-1:0] r_timer, r_win_cap;
    logic [SW-1:0] r_settle;
    result_t       r_result;

    tdc_edge_detect u_start_edge (.clk(clk), .reset(reset), .i_sig(start), .o_rise(w_start_edge));
    tdc_edge_detect u_stop_edge  (.clk(clk), .reset(reset), .i_sig(stop),  .o_rise(w_stop_edge));

    // A stop edge coincident with the start edge is remembered so the window closes after one cycle.
    assign w_stop_hit  = w_stop_edge | r_stop_seen;
    assign w_win_full  = (r_timer == WIN_LIMIT);
    assign w_has_ready = (r_settle >= SETTLE_MIN) && cnt_has_value;
    assign w_capture   = w_has_ready || (r_settle == SETTLE_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (arm)                       w_next_state = CLEAR;
            CLEAR:   if (r_clear == CLEAR_LAST)     w_next_state = ARMED;
            ARMED:   if (w_start_edge)              w_next_state = MEASURE;
            MEASURE: if (w_stop_hit || w_win_full)  w_next_state = SETTLE;
            SETTLE:  if (w_capture)                 w_next_state = HOLD;
            HOLD:    if (result_ready)              w_next_state = IDLE;
            default:                                w_next_state = IDLE;
        endcase
    end

    // Counter controls are decoded from the next state so the registered outputs track the FSM.
    always_comb begin
        w_cnt_enable_d = (w_next_state == MEASURE);
        w_cnt_reset_d  = (w_next_state == IDLE) || (w_next_state == CLEAR);
        w_valid_d      = (w_next_state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_enable  <= 1'b0;
            r_cnt_reset   <= 1'b1;
            r_valid       <= 1'b0;
            r_stop_seen   <= 1'b0;
            r_clear       <= '0;
            r_timer       <= '0;
            r_settle      <= '0;
            r_win_cap     <= '0;
            r_timeout_cap <= 1'b0;
            r_result      <= '0;
        end else begin
            r_cnt_enable <= w_cnt_enable_d;
            r_cnt_reset  <= w_cnt_reset_d;
            r_valid      <= w_valid_d;
            r_stop_seen  <= (r_state == ARMED) && w_start_edge && w_stop_edge;
            r_clear      <= (r_state == CLEAR)  ? r_clear + CLEAR_ONE   : CLEAR_ONE;
            r_settle     <= (r_state == SETTLE) ? r_settle + SETTLE_ONE : SETTLE_ONE;

            case (r_state)
                ARMED:   r_timer <= TIMER_ONE;
                MEASURE: r_timer <= (w_next_state == MEASURE) ? r_timer + TIMER_ONE : r_timer;
                default: r_timer <= '0;
            endcase

            if (r_state == MEASURE && w_next_state == SETTLE) begin
                r_win_cap     <= r_timer;
                r_timeout_cap <= w_win_full && !w_stop_hit;
            end

            if (r_state == SETTLE && w_next_state == HOLD) begin
                r_result <= '{count: cnt_value, window: r_win_cap,
                              timeout: r_timeout_cap, stale: !w_has_ready};
            end
        end
    end

    assign cnt_enable     = r_cnt_enable;
    assign cnt_reset      = r_cnt_reset;
    assign result         = r_result.count;
    assign result_window  = r_result.window;
    assign result_timeout = r_result.timeout;
    assign result_stale   = r_result.stale;
    assign result_valid   = r_valid;
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_tdc_window_controller.sv
// Directed bench for tdc_window_controller: a default instance and a MAX_WINDOW=64 instance share stimulus.
module tb_tdc_window_controller;

    localparam int CLEAR_N  = 4;
    localparam int SETTLE_N = 8;

    typedef struct {
        bit          use_w64;
        bit          stop_first;
        bit          same_cycle;
        int          win;
        int          hv;
        logic [31:0] value;
        int          exp_window;
        bit          exp_timeout;
        bit          exp_stale;
        int          exp_settle;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0, arm = 1'b0, start = 1'b0, stop = 1'b0;
    logic        cnt_has_value = 1'b0, result_ready = 1'b0, use_w64 = 1'b0;
    logic [31:0] cnt_value = '0;

    logic        a_en, a_rst, a_to, a_st, a_valid, a_busy;
    logic [31:0] a_result;
    logic [12:0] a_window;
    logic        b_en, b_rst, b_to, b_st, b_valid, b_busy;
    logic [31:0] b_result;
    logic [6:0]  b_window;

    logic        s_en, s_rst, s_to, s_st, s_valid, s_busy;
    logic [31:0] s_result;
    logic [12:0] s_window;

    int n_pass = 0;
    int n_total = 0;

    tdc_window_controller u_dut (
        .clk(clk), .reset(reset), .arm(arm), .start(start), .stop(stop),
        .cnt_enable(a_en), .cnt_reset(a_rst), .cnt_value(cnt_value), .cnt_has_value(cnt_has_value),
        .result(a_result), .result_window(a_window), .result_timeout(a_to), .result_stale(a_st),
        .result_valid(a_valid), .result_ready(result_ready), .busy(a_busy)
    );

    tdc_window_controller #(.MAX_WINDOW(64)) u_dut_w64 (
        .clk(clk), .reset(reset), .arm(arm), .start(start), .stop(stop),
        .cnt_enable(b_en), .cnt_reset(b_rst), .cnt_value(cnt_value), .cnt_has_value(cnt_has_value),
        .result(b_result), .result_window(b_window), .result_timeout(b_to), .result_stale(b_st),
        .result_valid(b_valid), .result_ready(result_ready), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (use_w64) begin
            s_en = b_en; s_rst = b_rst; s_to = b_to; s_st = b_st; s_valid = b_valid; s_busy = b_busy;
            s_result = b_result; s_window = {6'd0, b_window};
        end else begin
            s_en = a_en; s_rst = a_rst; s_to = a_to; s_st = a_st; s_valid = a_valid; s_busy = a_busy;
            s_result = a_result; s_window = a_window;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_to_hold(input vec_t v, input string tag);
        int n;
        use_w64 = v.use_w64;
        reset = 1'b0;
        tick();
        check({tag, ".rst_enable"}, s_en, 0);
        check({tag, ".rst_cnt_reset"}, s_rst, 1);
        check({tag, ".rst_valid"}, s_valid, 0);
        check({tag, ".rst_busy"}, s_busy, 0);
        check({tag, ".rst_result"}, {s_result, s_window, s_to, s_st}, 0);
        reset = 1'b1;
        arm = 1'b1;
        tick();
        check({tag, ".busy_after_arm"}, s_busy, 1);
        arm = 1'b0;
        n = 0;
        while (s_rst && n < 50) begin n++; tick(); end
        check({tag, ".clear_cycles"}, n, CLEAR_N);
        if (v.stop_first) begin
            stop = 1'b1;
            tick();
            check({tag, ".lone_stop_ignored"}, {s_en, s_busy}, 2'b01);
            stop = 1'b0;
            tick();
        end
        start = 1'b1;
        stop  = v.same_cycle;
        tick();
        check({tag, ".enable_latency"}, s_en, 1);
        n = 0;
        while (s_en && n < 5000) begin
            n++;
            if (n == v.win) stop = 1'b1;
            tick();
        end
        check({tag, ".enable_cycles"}, n, v.exp_window);
        cnt_value = v.value;
        n = 0;
        do begin
            n++;
            if (n == v.hv) cnt_has_value = 1'b1;
            tick();
        end while (!s_valid && n < 200);
        check({tag, ".settle_cycles"}, n, v.exp_settle);
        check({tag, ".result"}, s_result, v.value);
        check({tag, ".window"}, s_window, v.exp_window);
        check({tag, ".timeout"}, s_to, v.exp_timeout);
        check({tag, ".stale"}, s_st, v.exp_stale);
    endtask

    task automatic release_hold(input vec_t v, input string tag);
        cnt_value     = ~v.value;
        cnt_has_value = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        repeat (3) tick();
        check({tag, ".held"}, {s_valid, s_result, s_window}, {1'b1, v.value, 13'(v.exp_window)});
        result_ready = 1'b1;
        tick();
        check({tag, ".after_ready"}, {s_valid, s_busy, s_rst}, 3'b001);
        result_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   bad;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 100, 3,  32'h0000_1234, 100, 1'b0, 1'b0, SETTLE_N};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 0,   1,  32'hDEAD_BEEF, 1,   1'b0, 1'b0, SETTLE_N};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 5,   0,  32'h0000_00FF, 5,   1'b0, 1'b1, 4 * SETTLE_N};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2,   12, 32'hA5A5_0001, 2,   1'b0, 1'b0, 12};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 0,   2,  32'h0000_0040, 64,  1'b1, 1'b0, SETTLE_N};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 64,  20, 32'h0000_0007, 64,  1'b0, 1'b0, 20};

        for (int i = 0; i < 6; i++) begin
            run_to_hold(vecs[i], $sformatf("v%0d", i));
            release_hold(vecs[i], $sformatf("v%0d", i));
        end

        // HOLD must ignore arm and start pulses while readout stalls.
        run_to_hold(vecs[0], "hold");
        cnt_value = 32'h5555_5555;
        arm = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick();
            if (!(s_valid && !s_en && s_busy && s_result == 32'h1234 && s_window == 13'd100)) bad++;
        end
        check("hold.stable_cycles_bad", bad, 0);
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        check("hold.idle_after_ready", {s_valid, s_busy, s_rst}, 3'b001);
        result_ready = 1'b0;
        tick();
        check("hold.rearm_busy", s_busy, 1);
        begin
            int n = 0;
            while (s_rst && n < 50) begin n++; tick(); end
            check("hold.rearm_clear_cycles", n, CLEAR_N);
        end
        arm = 1'b0;

        // Synchronous reset while measuring aborts everything on the next edge.
        start = 1'b1;
        tick();
        repeat (3) tick();
        check("abort.measuring", s_en, 1);
        reset = 1'b0;
        tick();
        check("abort.outputs", {s_en, s_rst, s_busy, s_valid}, 4'b0100);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("abort.stays_idle", {s_en, s_busy}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
